led_sched: RTL and testbench
============================

Name: led_sched

Overview:
- Multi-channel LED timing scheduler.
- Derives a 1 ms tick from the 50 MHz board clock with a shared prescaler and sequences four LED channels from that tick.
- Each channel is programmed over a valid/ready command port as OFF, ON, BLINK or ONESHOT with a period in ms.
- Replaces per-LED free-running dividers; sits between control logic and board LED pins.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1000, scheduler tick rate in Hz. TICK_DIV = CLK_HZ/TICK_HZ (integer, >= 2).
- PER_W, 16, width of the period field and per-channel tick counter.

Ports:
- clk_50M  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_ch  in  2  target channel 0..3.
- cmd_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=ONESHOT.
- cmd_period  in  PER_W  period in ticks (ms).
- led_out  out  4  registered LED drives, bit n = channel n.
- done_pulse  out  4  one-cycle pulse when a channel's ONESHOT completes.
- tick_1ms  out  1  one-cycle tick strobe.

Behaviour:
- Reset (asserted async, held while rst=1):
  - prescaler=0, tick_1ms=0.
  - All channels: mode=OFF, period=0, cnt=0.
  - led_out=0, done_pulse=0, cmd_ready=1, FSM=IDLE.
  - Reset mid-operation aborts everything; no done_pulse is produced.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick_1ms=1 for the single cycle after the prescaler value was TICK_DIV-1.
  - First tick occurs exactly TICK_DIV cycles after reset release.
- Command FSM:
  - IDLE: cmd_ready=1. cmd_valid&cmd_ready captures ch/mode/period and moves to APPLY.
  - APPLY: cmd_ready=0 for exactly one cycle. Writes the channel config, then returns to IDLE.
  - Max throughput is one command per 2 cycles. cmd_valid held high accepts back-to-back commands at cycles n, n+2, ...
- Effective period: Peff = (period==0) ? 1 : period.
- APPLY effects on the target channel:
  - cnt<=0.
  - led<=0 for OFF, 1 for ON/BLINK/ONESHOT.
  - done_pulse is not asserted.
  - Visible on led_out the cycle after APPLY.
- Per-channel tick action, in BLINK/ONESHOT only:
  - if cnt==Peff-1: cnt<=0 and a period event fires; else cnt<=cnt+1.
  - OFF/ON channels ignore ticks; cnt holds at 0.
- BLINK period event: led toggles. Result is Peff ms high, Peff ms low. The first high phase lasts Peff ticks after APPLY, i.e. (Peff-1)..Peff ms of wall time.
- ONESHOT period event: led<=0, mode<=OFF, done_pulse[ch]=1 for one cycle, aligned with the LED falling edge.
- Simultaneous events:
  - APPLY on the same cycle as a tick: APPLY wins for the target channel, and that tick is ignored for it. Other channels process the tick normally.
  - Re-programming a running ONESHOT restarts or replaces it with no done_pulse for the aborted shot.
  - Several channels may pulse done_pulse in the same cycle.
- Width: cnt is PER_W bits and never exceeds Peff-1, so no overflow. period=2^PER_W-1 is legal.
- All outputs are registered; no combinational path from inputs to outputs except none (cmd_ready comes from FSM state).

Test Plan:
- Sim uses CLK_HZ=1000, TICK_HZ=100, so TICK_DIV=10.
- Reset:
  - Pulse rst for 3 cycles mid-BLINK → led_out=0, done_pulse=0, cmd_ready=1 immediately (async).
  - First tick_1ms appears 10 cycles after release; ticks are then spaced exactly 10 cycles apart.
- BLINK:
  - cmd ch0, mode=2, period=3 → led_out[0]=1 after APPLY.
  - Toggles to 0 on the 3rd tick, back to 1 on the 6th, 0 on the 9th.
  - Other channels stay 0.
- ONESHOT:
  - cmd ch2, mode=3, period=2 → led_out[2]=1, then falls on the 2nd tick.
  - done_pulse[2]=1 for exactly one cycle on that same cycle.
  - Further ticks cause no change.
- Handshake:
  - cmd_valid held high with two commands (ch1 ON, then ch3 ON) → accepted at cycles n and n+2.
  - cmd_ready=0 at n+1 and n+3; led_out=4'b1010 afterwards.
- Edge cases:
  - BLINK with period=0 → toggles on every tick.
  - Issue APPLY on the same cycle as a tick → target cnt=0 with the tick ignored; an unrelated BLINK channel still toggles.
- ONESHOT restart:
  - ONESHOT ch1 period=5; re-issue the same command after 3 ticks → no done_pulse at tick 5.
  - Single done_pulse[1] exactly 5 ticks after the second APPLY.

Source files
------------

// File: rtl/led_sched.sv
// rtl/led_sched.sv - four-channel LED scheduler sequenced from a shared millisecond tick
//
// Ports:
//   clk_50M     system clock (CLK_HZ)
//   rst         asynchronous active-high reset
//   cmd_valid   command present
//   cmd_ready   command accepted when high (IDLE state only)
//   cmd_ch      target channel 0..3
//   cmd_mode    0=OFF, 1=ON, 2=BLINK, 3=ONESHOT
//   cmd_period  period in ticks; 0 behaves as 1
//   led_out     registered LED drives, bit n = channel n
//   done_pulse  one-cycle strobe per channel when its ONESHOT expires
//   tick_1ms    one-cycle tick strobe
module led_sched #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int PER_W   = 16
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_ch,
  input  logic [1:0]       cmd_mode,
  input  logic [PER_W-1:0] cmd_period,
  output logic [3:0]       led_out,
  output logic [3:0]       done_pulse,
  output logic             tick_1ms
);

  localparam int               TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  typedef enum logic {S_IDLE, S_APPLY} state_t;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_w;
  logic             tick_q;

  state_t           state_q, state_d;
  logic [1:0]       cap_ch_q, cap_ch_d;
  logic [1:0]       cap_mode_q, cap_mode_d;
  logic [PER_W-1:0] cap_per_q, cap_per_d;

  logic [1:0]       mode_q [4];
  logic [1:0]       mode_d [4];
  logic [PER_W-1:0] per_q  [4];
  logic [PER_W-1:0] per_d  [4];
  logic [PER_W-1:0] cnt_q  [4];
  logic [PER_W-1:0] cnt_d  [4];
  logic [3:0]       led_q, led_d;
  logic [3:0]       done_q, done_d;

  // Last count value before a period event; a zero period acts as one tick.
  function automatic logic [PER_W-1:0] last_cnt(input logic [PER_W-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  // Channels act on the cycle the prescaler sits at its last value, so LED
  // changes land on the same edge that raises tick_1ms.
  assign tick_w = (pre_q == PRE_LAST);
  assign pre_d  = tick_w ? '0 : pre_q + 1'b1;

  assign cmd_ready  = (state_q == S_IDLE);
  assign led_out    = led_q;
  assign done_pulse = done_q;
  assign tick_1ms   = tick_q;

  always_comb begin
    state_d    = state_q;
    cap_ch_d   = cap_ch_q;
    cap_mode_d = cap_mode_q;
    cap_per_d  = cap_per_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cap_ch_d   = cmd_ch;
          cap_mode_d = cmd_mode;
          cap_per_d  = cmd_period;
          state_d    = S_APPLY;
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A pending APPLY takes priority over a coincident tick for its channel.
  always_comb begin
    led_d  = led_q;
    done_d = '0;
    for (int i = 0; i < 4; i++) begin
      mode_d[i] = mode_q[i];
      per_d[i]  = per_q[i];
      cnt_d[i]  = cnt_q[i];
      if (state_q == S_APPLY && cap_ch_q == 2'(i)) begin
        mode_d[i] = cap_mode_q;
        per_d[i]  = cap_per_q;
        cnt_d[i]  = '0;
        led_d[i]  = (cap_mode_q != MODE_OFF);
      end else if (tick_w && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_ONESHOT)) begin
        if (cnt_q[i] == last_cnt(per_q[i])) begin
          cnt_d[i] = '0;
          if (mode_q[i] == MODE_BLINK) begin
            led_d[i] = ~led_q[i];
          end else begin
            led_d[i]  = 1'b0;
            mode_d[i] = MODE_OFF;
            done_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      pre_q      <= '0;
      tick_q     <= 1'b0;
      state_q    <= S_IDLE;
      cap_ch_q   <= '0;
      cap_mode_q <= MODE_OFF;
      cap_per_q  <= '0;
      led_q      <= '0;
      done_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        mode_q[i] <= MODE_OFF;
        per_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      pre_q      <= pre_d;
      tick_q     <= tick_w;
      state_q    <= state_d;
      cap_ch_q   <= cap_ch_d;
      cap_mode_q <= cap_mode_d;
      cap_per_q  <= cap_per_d;
      led_q      <= led_d;
      done_q     <= done_d;
      for (int i = 0; i < 4; i++) begin
        mode_q[i] <= mode_d[i];
        per_q[i]  <= per_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_sched.sv
// tb/tb_led_sched.sv - randomized self-checking bench for led_sched against a tick-count model
module tb_led_sched;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ch;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_period;
  logic [3:0]  led_out;
  logic [3:0]  done_pulse;
  logic        tick_1ms;

  int n_run  = 0;
  int n_fail = 0;

  led_sched #(.CLK_HZ(1000), .TICK_HZ(100), .PER_W(16)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .led_out    (led_out),
    .done_pulse (done_pulse),
    .tick_1ms   (tick_1ms)
  );

  always #5 clk_50M = ~clk_50M;

  // Model: edge count since reset release decides ticks (every 10th edge);
  // each channel keeps the number of ticks seen since its last APPLY and the
  // LED level is derived from that count arithmetically.
  int         m_e;
  bit         m_busy;
  int         m_pch, m_pmode, m_pper;
  int         m_mode [4];
  int         m_peff [4];
  int         m_n    [4];
  logic [3:0] m_done;
  logic       m_tick;

  task automatic model_reset();
    m_e = 0; m_busy = 0; m_done = '0; m_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0; m_peff[i] = 1; m_n[i] = 0;
    end
  endtask

  function automatic logic [3:0] model_led();
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (m_mode[i])
        1:       r[i] = 1'b1;
        2:       r[i] = ((m_n[i] / m_peff[i]) % 2 == 0);
        3:       r[i] = (m_n[i] < m_peff[i]);
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic model_step();
    m_e++;
    m_tick = (m_e % 10 == 0);
    m_done = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_busy && m_pch == i) begin
        m_mode[i] = m_pmode;
        m_peff[i] = (m_pper == 0) ? 1 : m_pper;
        m_n[i]    = 0;
      end else if (m_tick && m_mode[i] >= 2) begin
        m_n[i]++;
        if (m_mode[i] == 3 && m_n[i] == m_peff[i]) begin
          m_mode[i] = 0; m_n[i] = 0; m_done[i] = 1'b1;
        end
      end
    end
    if (m_busy) begin
      m_busy = 0;
    end else if (cmd_valid) begin
      m_busy = 1; m_pch = int'(cmd_ch); m_pmode = int'(cmd_mode); m_pper = int'(cmd_period);
    end
  endtask

  task automatic cycle();
    @(posedge clk_50M);
    if (!rst) model_step();
    @(negedge clk_50M);
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  // Returns at the negedge after the acceptance edge (DUT now in APPLY).
  task automatic issue(input logic [1:0] ch, input logic [1:0] mode, input logic [15:0] per);
    int guard;
    guard = 0;
    cmd_ch = ch; cmd_mode = mode; cmd_period = per; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      cycle();
      guard++;
    end
    if (guard >= 20) begin
      n_run++; n_fail++;
      $display("FAIL issue_timeout cmd_ready=%b required 1", cmd_ready);
    end
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int first_tick;
    rst = 1'b1;
    cycle(); cycle();
    n_run++;
    if (led_out !== 4'b0 || done_pulse !== 4'b0 || cmd_ready !== 1'b1 || tick_1ms !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state led=%b done=%b rdy=%b tick=%b required 0000 0000 1 0", led_out, done_pulse, cmd_ready, tick_1ms);
    end
    rst = 1'b0;
    model_reset();
    issue(2'd0, 2'd2, 16'd3);
    repeat (25) cycle();
    n_run++;
    if (led_out !== 4'b0001) begin
      n_fail++; $display("FAIL reset_pre_blink led=%b required 0001", led_out);
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_run++;
    if (led_out !== 4'b0 || done_pulse !== 4'b0 || cmd_ready !== 1'b1 || tick_1ms !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async led=%b done=%b rdy=%b tick=%b required 0000 0000 1 0", led_out, done_pulse, cmd_ready, tick_1ms);
    end
    repeat (3) cycle();
    rst = 1'b0;
    first_tick = -1;
    for (int c = 1; c <= 45; c++) begin
      cycle();
      if (tick_1ms === 1'b1 && first_tick < 0) first_tick = c;
      n_run++;
      if (tick_1ms !== ((c % 10) == 0)) begin
        n_fail++; $display("FAIL tick_spacing cycle=%0d tick=%b required %b", c, tick_1ms, ((c % 10) == 0));
      end
    end
    n_run++;
    if (first_tick != 10) begin
      n_fail++; $display("FAIL first_tick at=%0d required 10", first_tick);
    end
  endtask

  task automatic test_blink();
    int   k;
    logic exp_b;
    apply_reset();
    issue(2'd0, 2'd2, 16'd3);
    cycle();
    n_run++;
    if (led_out !== 4'b0001) begin
      n_fail++; $display("FAIL blink_apply led=%b required 0001", led_out);
    end
    k = 0;
    for (int c = 0; c < 120 && k < 9; c++) begin
      cycle();
      if (m_tick) k++;
      n_run++;
      if (led_out !== model_led() || done_pulse !== 4'b0 || tick_1ms !== m_tick) begin
        n_fail++; $display("FAIL blink_model led=%b done=%b tick=%b required %b 0000 %b", led_out, done_pulse, tick_1ms, model_led(), m_tick);
      end
      if (m_tick && (k == 3 || k == 6 || k == 9)) begin
        exp_b = (k == 6);
        n_run++;
        if (led_out !== {3'b000, exp_b}) begin
          n_fail++; $display("FAIL blink_toggle tick=%0d led=%b required %b", k, led_out, {3'b000, exp_b});
        end
      end
    end
    n_run++;
    if (k != 9) begin
      n_fail++; $display("FAIL blink_ticks seen=%0d required 9", k);
    end
  endtask

  task automatic test_oneshot();
    int k, nd;
    apply_reset();
    issue(2'd2, 2'd3, 16'd2);
    cycle();
    n_run++;
    if (led_out !== 4'b0100) begin
      n_fail++; $display("FAIL oneshot_apply led=%b required 0100", led_out);
    end
    k = 0; nd = 0;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (m_tick) k++;
      if (done_pulse[2] === 1'b1) nd++;
      n_run++;
      if (led_out !== model_led() || done_pulse !== m_done) begin
        n_fail++; $display("FAIL oneshot_model led=%b done=%b required %b %b", led_out, done_pulse, model_led(), m_done);
      end
      if (m_tick && k == 2) begin
        n_run++;
        if (done_pulse !== 4'b0100 || led_out !== 4'b0000) begin
          n_fail++; $display("FAIL oneshot_end done=%b led=%b required 0100 0000", done_pulse, led_out);
        end
      end
    end
    n_run++;
    if (nd != 1 || led_out !== 4'b0000) begin
      n_fail++; $display("FAIL oneshot_count pulses=%0d led=%b required 1 0000", nd, led_out);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_mode = 2'd1; cmd_period = 16'd0;
    n_run++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_n rdy=%b required 1", cmd_ready);
    end
    cycle();
    n_run++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_n1 rdy=%b required 0", cmd_ready);
    end
    cmd_ch = 2'd3;
    cycle();
    n_run++;
    if (cmd_ready !== 1'b1 || led_out !== 4'b0010) begin
      n_fail++; $display("FAIL b2b_n2 rdy=%b led=%b required 1 0010", cmd_ready, led_out);
    end
    cycle();
    n_run++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_n3 rdy=%b required 0", cmd_ready);
    end
    cmd_valid = 1'b0;
    cycle();
    n_run++;
    if (cmd_ready !== 1'b1 || led_out !== 4'b1010 || led_out !== model_led()) begin
      n_fail++; $display("FAIL b2b_final rdy=%b led=%b required 1 1010", cmd_ready, led_out);
    end
  endtask

  task automatic test_period0();
    int k;
    apply_reset();
    issue(2'd0, 2'd2, 16'd0);
    cycle();
    k = 0;
    for (int c = 0; c < 80 && k < 6; c++) begin
      cycle();
      if (m_tick) begin
        k++;
        n_run++;
        if (led_out[0] !== (k % 2 == 0) || led_out !== model_led()) begin
          n_fail++; $display("FAIL period0_toggle tick=%0d led=%b required bit0=%b", k, led_out, (k % 2 == 0));
        end
      end
    end
    n_run++;
    if (k != 6) begin
      n_fail++; $display("FAIL period0_ticks seen=%0d required 6", k);
    end
  endtask

  task automatic test_apply_on_tick();
    logic prev3;
    int   guard;
    apply_reset();
    issue(2'd3, 2'd2, 16'd1);
    cycle();
    guard = 0;
    while (m_e % 10 != 8 && guard < 20) begin
      cycle();
      guard++;
    end
    prev3 = led_out[3];
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_mode = 2'd2; cmd_period = 16'd2;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    n_run++;
    if (tick_1ms !== 1'b1 || led_out[0] !== 1'b1 || led_out[3] !== ~prev3) begin
      n_fail++; $display("FAIL tick_apply tick=%b led=%b required tick 1 bit0 1 bit3 %b", tick_1ms, led_out, ~prev3);
    end
    repeat (10) cycle();
    n_run++;
    if (led_out[0] !== 1'b1 || led_out !== model_led()) begin
      n_fail++; $display("FAIL tick_apply_t1 led=%b required bit0 1 (%b)", led_out, model_led());
    end
    repeat (10) cycle();
    n_run++;
    if (led_out[0] !== 1'b0 || led_out !== model_led()) begin
      n_fail++; $display("FAIL tick_apply_t2 led=%b required bit0 0 (%b)", led_out, model_led());
    end
  endtask

  task automatic test_oneshot_restart();
    int k, k2, nd;
    apply_reset();
    issue(2'd1, 2'd3, 16'd5);
    cycle();
    k = 0;
    for (int c = 0; c < 60 && k < 3; c++) begin
      cycle();
      if (m_tick) k++;
    end
    issue(2'd1, 2'd3, 16'd5);
    cycle();
    k2 = 0; nd = 0;
    for (int c = 0; c < 90; c++) begin
      cycle();
      if (m_tick) k2++;
      if (done_pulse[1] === 1'b1) begin
        nd++;
        n_run++;
        if (k2 != 5 || !m_tick) begin
          n_fail++; $display("FAIL restart_when done at tick %0d required tick 5", k2);
        end
      end
    end
    n_run++;
    if (nd != 1) begin
      n_fail++; $display("FAIL restart_count pulses=%0d required 1", nd);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_ch     = 2'($urandom_range(0, 3));
      cmd_mode   = 2'($urandom_range(0, 3));
      cmd_period = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 4));
      cycle();
      n_run++;
      if (led_out !== model_led() || done_pulse !== m_done || cmd_ready !== !m_busy || tick_1ms !== m_tick) begin
        n_fail++;
        $display("FAIL random c=%0d got led=%b done=%b rdy=%b tick=%b want %b %b %b %b",
                 c, led_out, done_pulse, cmd_ready, tick_1ms, model_led(), m_done, !m_busy, m_tick);
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_mode = '0; cmd_period = '0;
    model_reset();
    test_reset();
    test_blink();
    test_oneshot();
    test_back_to_back();
    test_period0();
    test_apply_on_tick();
    test_oneshot_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
